// File: rtl/norm2_frame_loader.sv
// Frame loader and run controller for the norm2 sum-of-squares kernel: streams one
// frame into the kernel array, starts the kernel, and returns its result with status flags.
module norm2_frame_loader #(
  parameter int N       = 1000,
  parameter int DATA_W  = 27,
  parameter int ADDR_W  = 10,
  parameter int ACC_W   = 64,
  parameter int TIMEOUT = 16384
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ACC_W-1:0]  m_data,
  output logic              m_short,
  output logic              m_overflow,
  output logic              m_timeout,
  output logic [15:0]       m_cycles,
  output logic              busy,
  output logic              k_r_enable,
  output logic              k_controlArr,
  output logic [ADDR_W-1:0] k_init_i,
  output logic [ACC_W-1:0]  k_init_acc,
  output logic              k_wen,
  output logic [ADDR_W-1:0] k_addr,
  output logic [DATA_W-1:0] k_wdata,
  input  logic              k_w_enable,
  input  logic [ACC_W-1:0]  k_result
);

  typedef enum logic [2:0] {
    IDLE, LOAD, FILL, DRAIN, SETTLE, START, RUN, OUT
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);
  localparam logic [15:0]       CNT_MAX  = 16'(TIMEOUT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [15:0]       cnt;
  logic              accept;

  assign s_ready    = (state == LOAD) || (state == DRAIN);
  assign accept     = s_valid && s_ready;
  assign busy       = (state != IDLE);
  assign k_init_i   = '0;
  assign k_init_acc = '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   state_nxt = LOAD;
      LOAD: begin
        if (accept) begin
          if (idx == LAST_IDX) state_nxt = s_last ? SETTLE : DRAIN;
          else if (s_last)     state_nxt = FILL;
        end
      end
      FILL:   if (idx == LAST_IDX) state_nxt = SETTLE;
      DRAIN:  if (accept && s_last) state_nxt = SETTLE;
      SETTLE: state_nxt = START;
      START:  state_nxt = RUN;
      RUN:    if (k_w_enable || cnt == CNT_MAX) state_nxt = OUT;
      OUT:    if (m_ready) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Kernel bus, frame index, run counter and result registers; all move with the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx          <= '0;
      cnt          <= '0;
      k_controlArr <= 1'b0;
      k_wen        <= 1'b0;
      k_addr       <= '0;
      k_wdata      <= '0;
      k_r_enable   <= 1'b0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_cycles     <= '0;
      m_short      <= 1'b0;
      m_overflow   <= 1'b0;
      m_timeout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          k_controlArr <= 1'b1;
          k_wen        <= 1'b0;
          idx          <= '0;
        end
        LOAD: begin
          if (accept) begin
            k_wen   <= 1'b1;
            k_addr  <= idx;
            k_wdata <= s_data;
            idx     <= idx + 1'b1;
            if (idx == LAST_IDX && !s_last) m_overflow <= 1'b1;
            if (idx != LAST_IDX && s_last)  m_short    <= 1'b1;
          end else begin
            k_wen <= 1'b0;
          end
        end
        FILL: begin
          k_wen   <= 1'b1;
          k_addr  <= idx;
          k_wdata <= '0;
          idx     <= idx + 1'b1;
        end
        DRAIN: k_wen <= 1'b0;
        SETTLE: begin
          k_wen        <= 1'b0;
          k_controlArr <= 1'b0;
          k_r_enable   <= 1'b1;
          cnt          <= '0;
        end
        START: k_r_enable <= 1'b0;
        RUN: begin
          // A finishing kernel wins over a timeout landing on the same cycle.
          if (k_w_enable) begin
            m_data   <= k_result;
            m_cycles <= cnt;
            m_valid  <= 1'b1;
          end else if (cnt == CNT_MAX) begin
            m_data    <= '0;
            m_cycles  <= cnt;
            m_timeout <= 1'b1;
            m_valid   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        OUT: begin
          if (m_ready) begin
            m_valid      <= 1'b0;
            m_short      <= 1'b0;
            m_overflow   <= 1'b0;
            m_timeout    <= 1'b0;
            k_controlArr <= 1'b1;
            idx          <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/norm2_frame_loader.md
Name: norm2_frame_loader

Overview:
- Upstream feeder and controller for the HLS-generated sum-of-squares kernel (`main`, norm2), which computes Σ a[i]² over a 1000-entry signed 27-bit array.
- Accepts one frame of samples on a valid/ready stream and writes them into the kernel's array through its controlArr back-door port.
- Then pulses the kernel's r_enable, waits for its w_enable, and presents the 64-bit result on a valid/ready output with status flags.

Parameters:
- N, 1000, array depth; frame length the kernel expects.
- DATA_W, 27, sample width; signed, two's complement.
- ADDR_W, 10, array address width; requires 2^ADDR_W ≥ N.
- ACC_W, 64, result width.
- TIMEOUT, 16384, maximum RUN cycles before abort.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  loader accepts a sample.
- s_data  in  DATA_W  signed sample.
- s_last  in  1  final sample of frame.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumer ready.
- m_data  out  ACC_W  signed sum of squares.
- m_short  out  1  frame ended before N samples; tail zero-filled.
- m_overflow  out  1  frame longer than N; excess samples dropped.
- m_timeout  out  1  kernel did not finish within TIMEOUT; m_data=0.
- m_cycles  out  16  RUN-state cycle count.
- busy  out  1  state≠IDLE.
- k_r_enable  out  1  to kernel r_enable.
- k_controlArr  out  1  to kernel controlArr.
- k_init_i  out  ADDR_W  to kernel init_i; constant 0.
- k_init_acc  out  ACC_W  to kernel init_acc; constant 0.
- k_wen  out  1  to controlArrWEnable_a.
- k_addr  out  ADDR_W  to controlArrAddr_a.
- k_wdata  out  DATA_W  to controlArrWData_a.
- k_w_enable  in  1  from kernel w_enable.
- k_result  in  ACC_W  from kernel result.

Behaviour:
- Reset values (asynchronous): state=IDLE; all outputs 0; idx=0; cycle counter=0; all flags 0. controlArrRData_a is not used by this block.
- Kernel-facing outputs (k_*) are registered. k_wen=1 only while k_controlArr=1.
- States: IDLE, LOAD, FILL, DRAIN, SETTLE, START, RUN, OUT.
- IDLE:
  - s_ready=0.
  - Next cycle → LOAD, with k_controlArr←1 and idx←0.
- LOAD:
  - s_ready=1.
  - On each s_valid&&s_ready: register k_wen=1, k_addr=idx, k_wdata=s_data; idx++.
  - When no beat is accepted, register k_wen=0.
  - Accepted beat with idx=N-1 and s_last → SETTLE.
  - Accepted beat with idx=N-1 and !s_last → DRAIN; m_overflow←1.
  - Accepted beat with s_last and idx<N-1 → FILL; m_short←1.
- FILL:
  - s_ready=0.
  - One zero write per cycle at addresses idx..N-1.
  - After address N-1 is registered → SETTLE.
- DRAIN:
  - s_ready=1; accepted beats are discarded (k_wen=0).
  - Accepted beat with s_last → SETTLE.
- SETTLE:
  - One cycle; the final write is on the bus with k_controlArr=1.
  - Then registers k_wen=0, k_controlArr=0 → START.
- START:
  - One cycle, k_r_enable=1, k_controlArr=0, k_init_i=0, k_init_acc=0.
  - Clears the kernel's stale w_enable → RUN.
- RUN:
  - k_r_enable=0, k_controlArr=0; cycle counter increments each cycle.
  - On k_w_enable=1: capture k_result into m_data and the count into m_cycles → OUT.
  - If count reaches TIMEOUT-1 first: m_timeout←1, m_data←0 → OUT.
- OUT:
  - m_valid=1; m_data and flags are held stable until m_valid&&m_ready.
  - On handshake: m_valid←0, flags clear → LOAD for the next frame.
  - Result valid/ready is independent of s_*; s_ready=0 while in OUT.
- Boundary and corner cases:
  - An s_last beat in DRAIN terminates the frame.
  - s_valid without a s_last-terminated frame never times out in LOAD.
  - A single-sample frame (s_last on idx=0) gives FILL of N-1 zeros.
- Reset mid-operation:
  - Immediately deasserts k_controlArr/k_wen/k_r_enable and drops any partial frame.
  - The kernel is left free-running and is resynchronised by the next START pulse.
- Arithmetic: the kernel's result is passed through unmodified. Worst case N·(2^26)² = 4503599627370496000 < 2^63, so there is no overflow.

Test Plan:
- Samples 1..1000, s_last on 1000th, m_ready=1 → m_data=333833500, all flags 0, m_cycles ≈ 9N (matches kernel model).
- Frame −2, 5, 7 with s_last on 3rd → 997 zero writes; m_data=78, m_short=1.
- 1002 samples of value 1, s_last on 1002nd → m_data=1000, m_overflow=1; the 1001st/1002nd samples are never written (k_wen=0 in DRAIN).
- 1000 samples of −2^26 → m_data=4503599627370496000, no sign corruption.
- Random s_valid gaps (50%) and m_ready held low for 20 cycles in OUT → m_data stable throughout; the next frame completes correctly; k_wen never =1 with k_controlArr=0 (assertion).
- rst asserted mid-LOAD (idx=400) and mid-RUN → outputs zero asynchronously; the next full frame of all 3s gives m_data=9000. A kernel stub that never raises w_enable → m_timeout=1, m_data=0 after TIMEOUT cycles.
